// File: rtl/jt51_pg_sched_if.sv
// Register-write bus into the phase-generator slot scheduler.
// The driver writes the channel, operator and key-on tables through it.
interface jt51_pg_sched_if;
  logic       ch_we;
  logic [2:0] ch_sel;
  logic [6:0] kc_din;
  logic [5:0] kf_din;
  logic [2:0] pms_din;
  logic       op_we;
  logic [4:0] op_sel;
  logic [3:0] mul_din;
  logic [2:0] dt1_din;
  logic [1:0] dt2_din;
  logic       kon_we;
  logic [2:0] kon_ch;
  logic [3:0] kon_ops;

  modport master (
    output ch_we, ch_sel, kc_din, kf_din, pms_din,
    output op_we, op_sel, mul_din, dt1_din, dt2_din,
    output kon_we, kon_ch, kon_ops
  );

  modport slave (
    input ch_we, ch_sel, kc_din, kf_din, pms_din,
    input op_we, op_sel, mul_din, dt1_din, dt2_din,
    input kon_we, kon_ch, kon_ops
  );
endinterface

// File: rtl/jt51_pg_sched.sv
// Slot counter and parameter sequencer for the JT51 phase generator.
// Drives per-slot fields at stage offsets I/II/III/VI and key-on resets.
module jt51_pg_sched (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  jt51_pg_sched_if.slave wr,
  output logic [4:0]  slot_I,
  output logic        zero,
  output logic [6:0]  kc_I,
  output logic [5:0]  kf_I,
  output logic [2:0]  pms_I,
  output logic [1:0]  dt2_I,
  output logic [2:0]  dt1_II,
  output logic        pg_rst_III,
  output logic [3:0]  mul_VI,
  output logic [31:0] kon_o
);

  logic [6:0]  kc_q  [8];
  logic [5:0]  kf_q  [8];
  logic [2:0]  pms_q [8];
  logic [3:0]  mul_q [32];
  logic [2:0]  dt1_q [32];
  logic [1:0]  dt2_q [32];

  logic [4:0]  slot_q;
  logic [4:0]  nxt;
  logic [6:0]  kc_I_q;
  logic [5:0]  kf_I_q;
  logic [2:0]  pms_I_q;
  logic [1:0]  dt2_I_q;
  logic [2:0]  dt1_I_q;
  logic [2:0]  dt1_II_q;
  logic [2:0]  pr_q;
  logic [3:0]  mul_p_q [6];
  logic [31:0] kon_q, kon_d;
  logic [31:0] pend_q, pend_d;
  logic [4:0]  idx;

  assign nxt = slot_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        kc_q[i]  <= '0;
        kf_q[i]  <= '0;
        pms_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        mul_q[i] <= '0;
        dt1_q[i] <= '0;
        dt2_q[i] <= '0;
      end
    end else begin
      if (wr.ch_we) begin
        kc_q[wr.ch_sel]  <= wr.kc_din;
        kf_q[wr.ch_sel]  <= wr.kf_din;
        pms_q[wr.ch_sel] <= wr.pms_din;
      end
      if (wr.op_we) begin
        mul_q[wr.op_sel] <= wr.mul_din;
        dt1_q[wr.op_sel] <= wr.dt1_din;
        dt2_q[wr.op_sel] <= wr.dt2_din;
      end
    end
  end

  // Every field of a slot is read from the tables on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      kc_I_q   <= '0;
      kf_I_q   <= '0;
      pms_I_q  <= '0;
      dt2_I_q  <= '0;
      dt1_I_q  <= '0;
      dt1_II_q <= '0;
      pr_q     <= '0;
      for (int i = 0; i < 6; i++) mul_p_q[i] <= '0;
    end else if (cen) begin
      slot_q     <= nxt;
      kc_I_q     <= kc_q[nxt[2:0]];
      kf_I_q     <= kf_q[nxt[2:0]];
      pms_I_q    <= pms_q[nxt[2:0]];
      dt2_I_q    <= dt2_q[nxt];
      dt1_I_q    <= dt1_q[nxt];
      dt1_II_q   <= dt1_I_q;
      pr_q       <= {pr_q[1:0], pend_q[nxt]};
      mul_p_q[0] <= mul_q[nxt];
      for (int i = 1; i < 6; i++) mul_p_q[i] <= mul_p_q[i-1];
    end
  end

  // Clear of the consumed slot comes first so a same-edge rise wins.
  always_comb begin
    kon_d  = kon_q;
    pend_d = pend_q;
    idx    = '0;
    if (cen) pend_d[nxt] = 1'b0;
    if (wr.kon_we) begin
      for (int n = 0; n < 4; n++) begin
        idx = {n[1:0], wr.kon_ch};
        kon_d[idx] = wr.kon_ops[n];
        if (wr.kon_ops[n] && !kon_q[idx]) pend_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kon_q  <= '0;
      pend_q <= '0;
    end else begin
      kon_q  <= kon_d;
      pend_q <= pend_d;
    end
  end

  assign slot_I     = slot_q;
  assign zero       = (slot_q == 5'd0);
  assign kc_I       = kc_I_q;
  assign kf_I       = kf_I_q;
  assign pms_I      = pms_I_q;
  assign dt2_I      = dt2_I_q;
  assign dt1_II     = dt1_II_q;
  assign pg_rst_III = pr_q[2];
  assign mul_VI     = mul_p_q[5];
  assign kon_o      = kon_q;

endmodule

// File: tb/tb_jt51_pg_sched.sv
// Bench for jt51_pg_sched: directed scenarios plus random traffic,
// checked each cycle against a history-of-loads reference model.
module tb_jt51_pg_sched;

  logic        rst, clk, cen;
  logic [4:0]  slot_I;
  logic        zero;
  logic [6:0]  kc_I;
  logic [5:0]  kf_I;
  logic [2:0]  pms_I;
  logic [1:0]  dt2_I;
  logic [2:0]  dt1_II;
  logic        pg_rst_III;
  logic [3:0]  mul_VI;
  logic [31:0] kon_o;

  jt51_pg_sched_if wr();

  jt51_pg_sched dut (
    .rst(rst), .clk(clk), .cen(cen), .wr(wr),
    .slot_I(slot_I), .zero(zero), .kc_I(kc_I), .kf_I(kf_I),
    .pms_I(pms_I), .dt2_I(dt2_I), .dt1_II(dt1_II),
    .pg_rst_III(pg_rst_III), .mul_VI(mul_VI), .kon_o(kon_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] kc;
    logic [5:0] kf;
    logic [2:0] pms;
    logic [1:0] dt2;
    logic [2:0] dt1;
    logic [3:0] mul;
    logic       pr;
  } ent_t;

  int total = 0;
  int bad = 0;

  logic [6:0] m_kc [8];
  logic [5:0] m_kf [8];
  logic [2:0] m_pms [8];
  logic [3:0] m_mul [32];
  logic [2:0] m_dt1 [32];
  logic [1:0] m_dt2 [32];
  bit   [31:0] m_kon, m_pend;
  int   m_slot;
  ent_t hist [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_kc[i] = 0; m_kf[i] = 0; m_pms[i] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      m_mul[i] = 0; m_dt1[i] = 0; m_dt2[i] = 0;
    end
    m_kon = 0; m_pend = 0; m_slot = 0;
    hist = {};
    repeat (6) hist.push_front('0);
  endtask

  // Loads read the tables before that edge's writes take effect.
  task automatic model_edge(input bit c);
    ent_t e;
    int s, id;
    if (c) begin
      s = (m_slot + 1) % 32;
      e.kc = m_kc[s % 8]; e.kf = m_kf[s % 8]; e.pms = m_pms[s % 8];
      e.dt2 = m_dt2[s]; e.dt1 = m_dt1[s]; e.mul = m_mul[s];
      e.pr = m_pend[s];
      m_pend[s] = 0;
      hist.push_front(e);
      void'(hist.pop_back());
      m_slot = s;
    end
    if (wr.ch_we) begin
      m_kc[wr.ch_sel] = wr.kc_din;
      m_kf[wr.ch_sel] = wr.kf_din;
      m_pms[wr.ch_sel] = wr.pms_din;
    end
    if (wr.op_we) begin
      m_mul[wr.op_sel] = wr.mul_din;
      m_dt1[wr.op_sel] = wr.dt1_din;
      m_dt2[wr.op_sel] = wr.dt2_din;
    end
    if (wr.kon_we) begin
      for (int n = 0; n < 4; n++) begin
        id = n * 8 + int'(wr.kon_ch);
        if (wr.kon_ops[n] && !m_kon[id]) m_pend[id] = 1;
        m_kon[id] = wr.kon_ops[n];
      end
    end
  endtask

  task automatic check_all();
    chk("slot_I", 32'(slot_I), 32'(m_slot));
    chk("zero", 32'(zero), 32'(m_slot == 0));
    chk("kc_I", 32'(kc_I), 32'(hist[0].kc));
    chk("kf_I", 32'(kf_I), 32'(hist[0].kf));
    chk("pms_I", 32'(pms_I), 32'(hist[0].pms));
    chk("dt2_I", 32'(dt2_I), 32'(hist[0].dt2));
    chk("dt1_II", 32'(dt1_II), 32'(hist[1].dt1));
    chk("pg_rst_III", 32'(pg_rst_III), 32'(hist[2].pr));
    chk("mul_VI", 32'(mul_VI), 32'(hist[5].mul));
    chk("kon_o", kon_o, m_kon);
  endtask

  task automatic clr_wr();
    wr.ch_we = 0; wr.op_we = 0; wr.kon_we = 0;
  endtask

  task automatic tick(input bit c);
    cen = c;
    @(posedge clk);
    model_edge(c);
    #1;
    check_all();
    clr_wr();
  endtask

  task automatic run_to(input int t);
    int g = 0;
    while (m_slot != t && g < 64) begin
      tick(1);
      g++;
    end
    chk("run_to", 32'(slot_I), 32'(t));
  endtask

  task automatic ch_wr(input int ch, input int kc, input int kf,
                       input int pms);
    wr.ch_we = 1; wr.ch_sel = 3'(ch);
    wr.kc_din = 7'(kc); wr.kf_din = 6'(kf); wr.pms_din = 3'(pms);
  endtask

  task automatic op_wr(input int op, input int mul, input int dt1,
                       input int dt2);
    wr.op_we = 1; wr.op_sel = 5'(op);
    wr.mul_din = 4'(mul); wr.dt1_din = 3'(dt1); wr.dt2_din = 2'(dt2);
  endtask

  task automatic kon_wr(input int ch, input int ops);
    wr.kon_we = 1; wr.kon_ch = 3'(ch); wr.kon_ops = 4'(ops);
  endtask

  initial begin
    int zc, hits, pc, psum;
    logic [6:0] kc_snap;
    logic [4:0] sl_snap;
    logic [3:0] mul_snap;

    rst = 1; cen = 0;
    clr_wr();
    wr.ch_sel = 0; wr.kc_din = 0; wr.kf_din = 0; wr.pms_din = 0;
    wr.op_sel = 0; wr.mul_din = 0; wr.dt1_din = 0; wr.dt2_din = 0;
    wr.kon_ch = 0; wr.kon_ops = 0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 0;

    // frame walk from reset
    zc = zero ? 1 : 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (zero) zc++;
    end
    chk("zero_count", 32'(zc), 32'd2);
    tick(1);
    chk("slot_after_33", 32'(slot_I), 32'd1);

    // channel 3 parameters
    ch_wr(3, 'h4A, 'h10, 5);
    tick(1);
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (kc_I == 7'h4A && kf_I == 6'h10 && pms_I == 3'd5) begin
        hits++;
        chk("kc_slot", 32'(slot_I[2:0]), 32'd3);
      end
    end
    chk("kc_hits", 32'(hits), 32'd4);

    // operator 9 parameters at their stage offsets
    run_to(20);
    op_wr(9, 7, 6, 2);
    tick(1);
    run_to(9);
    chk("dt2_at9", 32'(dt2_I), 32'd2);
    tick(1);
    chk("dt1_at10", 32'(dt1_II), 32'd6);
    run_to(14);
    chk("mul_at14", 32'(mul_VI), 32'd7);

    // key-on channel 2, operators 0 and 2
    kon_wr(2, 4'b0101);
    tick(1);
    pc = 0; psum = 0;
    for (int i = 0; i < 34; i++) begin
      tick(1);
      if (pg_rst_III) begin
        pc++;
        psum += int'(slot_I);
      end
    end
    chk("kon_pulses", 32'(pc), 32'd2);
    chk("kon_pulse_slots", 32'(psum), 32'd24);
    pc = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (pg_rst_III) pc++;
    end
    chk("kon_no_repeat", 32'(pc), 32'd0);
    chk("kon_o_2", 32'(kon_o[2]), 32'd1);
    chk("kon_o_18", 32'(kon_o[18]), 32'd1);

    // write on the edge that loads slot 5
    run_to(4);
    op_wr(5, 3, 0, 0);
    tick(1);
    run_to(10);
    chk("mul5_old", 32'(mul_VI), 32'd0);
    tick(1);
    run_to(10);
    chk("mul5_new", 32'(mul_VI), 32'd3);

    // slot 7: rise again on the edge that consumes pending
    run_to(8);
    kon_wr(7, 1);
    tick(1);
    kon_wr(7, 0);
    tick(1);
    run_to(6);
    kon_wr(7, 1);
    tick(1);
    run_to(9);
    chk("s7_pulse_now", 32'(pg_rst_III), 32'd1);
    tick(1);
    run_to(9);
    chk("s7_pulse_next", 32'(pg_rst_III), 32'd1);
    tick(1);
    run_to(9);
    chk("s7_pulse_gone", 32'(pg_rst_III), 32'd0);

    // cen held low with a write in between
    kc_snap = kc_I; sl_snap = slot_I; mul_snap = mul_VI;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ch_wr(1, 'h33, 'h01, 2);
      tick(0);
    end
    chk("frz_slot", 32'(slot_I), 32'(sl_snap));
    chk("frz_kc", 32'(kc_I), 32'(kc_snap));
    chk("frz_mul", 32'(mul_VI), 32'(mul_snap));
    tick(1);
    run_to(9);
    chk("frz_write_seen", 32'(kc_I), 32'h33);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0)
        ch_wr($urandom_range(0, 7), $urandom_range(0, 127),
              $urandom_range(0, 63), $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0)
        op_wr($urandom_range(0, 31), $urandom_range(0, 15),
              $urandom_range(0, 7), $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        kon_wr($urandom_range(0, 7), $urandom_range(0, 15));
      tick($urandom_range(0, 3) != 0);
    end

    // reset mid-frame
    run_to(13);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0)
        kon_wr($urandom_range(0, 7), $urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0)
        op_wr($urandom_range(0, 31), $urandom_range(0, 15),
              $urandom_range(0, 7), $urandom_range(0, 3));
      tick($urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt51_pg_sched.md
Name: jt51_pg_sched

Overview:
- Slot scheduler and parameter sequencer for the phase generator.
- Holds per-channel and per-operator frequency parameters and steps a 32-slot counter.
- Presents each slot's parameters to the phase generator at that pipeline's stage offsets: I for kc/kf/pms/dt2, II for dt1, III for the phase reset, VI for mul.
- Converts key-on rising edges into single-slot phase-reset pulses and generates the frame-start `zero` marker.

Parameters:
- None. The slot count is fixed at 32 (8 channels x 4 operators).

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  clock enable; slot advance and pipeline shift occur only when high
- ch_we  in  1  channel register write strobe
- ch_sel  in  3  channel index for ch_we
- kc_din  in  7  key code
- kf_din  in  6  key fraction
- pms_din  in  3  PM sensitivity
- op_we  in  1  operator register write strobe
- op_sel  in  5  slot index for op_we, where slot = {op[1:0], ch[2:0]}
- mul_din  in  4  multiplier
- dt1_din  in  3  detune 1
- dt2_din  in  2  detune 2
- kon_we  in  1  key-on write strobe
- kon_ch  in  3  channel for kon_we
- kon_ops  in  4  key-on bit per operator; bit n maps to slot {n, kon_ch}
- slot_I  out  5  slot owning the current stage-I outputs
- zero  out  1  high when slot_I==0 (combinational from slot_I)
- kc_I  out  7  key code for slot_I
- kf_I  out  6  key fraction for slot_I
- pms_I  out  3  PM sensitivity for slot_I
- dt2_I  out  2  detune 2 for slot_I
- dt1_II  out  3  dt1 of slot_I-1 (mod 32)
- pg_rst_III  out  1  phase-reset pulse for slot_I-2 (mod 32)
- mul_VI  out  4  mul of slot_I-5 (mod 32)
- kon_o  out  32  current key-on state per slot, for the envelope block

Behaviour:
- Reset (async):
  - Forces slot_I=0.
  - Forces all data outputs, all delay registers, the channel table (8 entries), the operator table (32 entries), kon state and pending flags to 0.
  - zero therefore reads 1 during and after reset.
- Slot stepping (each clk edge with cen=1):
  - slot_I <= slot_I+1, wrapping 31->0.
  - Stage-I outputs load from the tables at index slot_I+1; channel fields are indexed by bits [2:0].
  - cen=0 holds slot_I and every pipeline register.
- Delay lines (shift on cen only):
  - dt1: 1 stage.
  - pg_rst: 2 stages.
  - mul: 5 stages.
  - Each delayed value is captured from the table at the same instant as its stage-I sibling, so all fields of one slot stay coherent.
- Register writes:
  - Sampled on every clk edge; they are not gated by cen.
  - The table is updated at that edge.
  - If a write targets the entry being loaded on the same edge, the load takes the OLD value (read-before-write); the new value appears on the slot's next visit.
- Key-on:
  - On kon_we, kon_o[{n,kon_ch}] <= kon_ops[n] for n=0..3.
  - Any 0->1 transition sets pending[slot].
  - 1->1 and 1->0 transitions do not touch pending.
- Phase-reset issue:
  - When the stage-I load selects slot s with pending[s]=1, the pg_rst pipeline input is 1 and pending[s] clears on that edge.
  - Result: pg_rst_III is high for exactly one cen period, two slots later.
  - Set and clear on the same edge for the same slot: set wins, so pending stays 1 and the pulse repeats on the next frame.
  - A key-off/key-on pair within one frame yields a single pulse.
- Pulse shape: at most one pulse per slot per frame; no pulse without a rising edge.
- Reset mid-frame: the pipeline is flushed; the counter restarts at slot 0 with a zero indication.

Test Plan:
- Reset release, 33 cen pulses -> slot_I steps 0,1..31,0,1.
  - zero is high at cycles 0 and 32 only.
  - All parameter outputs are 0.
- ch_we ch_sel=3 kc=0x4A kf=0x10 pms=5, then run a frame -> kc_I=0x4A, kf_I=0x10, pms_I=5 when slot_I is 3, 11, 19 or 27; 0 elsewhere.
- op_we op_sel=9 mul=7 dt1=6 dt2=2 -> dt2_I=2 at slot_I=9; dt1_II=6 at slot_I=10; mul_VI=7 at slot_I=14.
- kon_we ch=2 ops=4'b0101 -> pg_rst_III pulses exactly at slot_I=4 and slot_I=20.
  - No pulse on the next frame.
  - kon_o bits 2 and 18 are 1.
- Write op_sel=5 mul=3 on the edge that loads slot 5 -> the current visit carries the old mul (0 at slot_I=10); the next frame carries 3.
- kon rising edge for slot 7 on the edge consuming pending[7] -> pulse at slot_I=9 this frame and again next frame.
- cen held low for 10 clk with a write in between -> outputs frozen and the write is visible on the next visit.
